// File: rtl/display_mode_scheduler.sv
// Chooses which camera setting the seven-segment decoder shows. It supports manual
// stepping by push button, timed auto-scroll, and a temporary override when a value changes.
module display_mode_scheduler #(
    parameter int unsigned DWELL_CYCLES    = 50_000_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnNext,
    input  logic       autoEn,
    input  logic [3:0] isoValue,
    input  logic [3:0] shutterSpeedValue,
    input  logic [3:0] focalLenghtValue,
    input  logic [2:0] brightnessIndicatorValue,
    output logic [1:0] selectInput,
    output logic       overrideActive,
    output logic       modeChanged
);

    localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned BW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_RELOAD = DW'(DWELL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_RELOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] DB_RELOAD    = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_MANUAL   = 2'd0,
        ST_AUTO     = 2'd1,
        ST_OVERRIDE = 2'd2
    } state_t;

    logic          r_btn_meta;
    logic          r_btn_sync;
    logic          r_db_level;
    logic [BW-1:0] r_db_cnt;
    logic          r_next_pulse;

    logic [3:0]    r_prev_iso;
    logic [3:0]    r_prev_sh;
    logic [3:0]    r_prev_fo;
    logic          r_primed;

    state_t        r_state;
    state_t        r_ret;
    logic [1:0]    r_base;
    logic [1:0]    r_ov;
    logic [DW-1:0] r_dwell;
    logic [HW-1:0] r_hold;
    logic [1:0]    r_sel;
    logic          r_ov_active;
    logic          r_mode_changed;

    state_t        w_state_next;
    state_t        w_ret_next;
    logic [1:0]    w_base_next;
    logic [1:0]    w_ov_next;
    logic [DW-1:0] w_dwell_next;
    logic [HW-1:0] w_hold_next;
    logic [1:0]    w_sel_next;

    logic          w_chg_iso;
    logic          w_chg_sh;
    logic          w_chg_fo;
    logic          w_chg_any;
    logic [1:0]    w_chg_mode;
    logic          w_unused_bri;

    // The indicator value is routed to the decoder elsewhere; it never triggers an override.
    assign w_unused_bri = ^brightnessIndicatorValue;

    // Debounced level changes only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_meta   <= 1'b0;
            r_btn_sync   <= 1'b0;
            r_db_level   <= 1'b0;
            r_db_cnt     <= '0;
            r_next_pulse <= 1'b0;
        end else begin
            r_btn_meta   <= btnNext;
            r_btn_sync   <= r_btn_meta;
            r_next_pulse <= 1'b0;
            if (r_btn_sync == r_db_level) begin
                r_db_cnt <= DB_RELOAD;
            end else if (r_db_cnt == '0) begin
                r_db_level   <= r_btn_sync;
                r_db_cnt     <= DB_RELOAD;
                r_next_pulse <= r_btn_sync;
            end else begin
                r_db_cnt <= r_db_cnt - BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_iso <= '0;
            r_prev_sh  <= '0;
            r_prev_fo  <= '0;
            r_primed   <= 1'b0;
        end else begin
            r_prev_iso <= isoValue;
            r_prev_sh  <= shutterSpeedValue;
            r_prev_fo  <= focalLenghtValue;
            r_primed   <= 1'b1;
        end
    end

    assign w_chg_iso  = r_primed && (isoValue != r_prev_iso);
    assign w_chg_sh   = r_primed && (shutterSpeedValue != r_prev_sh);
    assign w_chg_fo   = r_primed && (focalLenghtValue != r_prev_fo);
    assign w_chg_any  = w_chg_iso | w_chg_sh | w_chg_fo;
    assign w_chg_mode = w_chg_iso ? 2'b00 : (w_chg_sh ? 2'b01 : 2'b10);

    always_comb begin
        w_state_next = r_state;
        w_ret_next   = r_ret;
        w_base_next  = r_base;
        w_ov_next    = r_ov;
        w_dwell_next = r_dwell;
        w_hold_next  = r_hold;
        unique case (r_state)
            ST_MANUAL: begin
                if (w_chg_any) begin
                    w_state_next = ST_OVERRIDE;
                    w_ret_next   = ST_MANUAL;
                    w_ov_next    = w_chg_mode;
                    w_hold_next  = HOLD_RELOAD;
                end else begin
                    if (r_next_pulse) w_base_next = r_base + 2'd1;
                    if (autoEn) begin
                        w_state_next = ST_AUTO;
                        w_dwell_next = DWELL_RELOAD;
                    end
                end
            end
            ST_AUTO: begin
                if (w_chg_any) begin
                    w_state_next = ST_OVERRIDE;
                    w_ret_next   = ST_AUTO;
                    w_ov_next    = w_chg_mode;
                    w_hold_next  = HOLD_RELOAD;
                end else begin
                    if (r_next_pulse || r_dwell == '0) begin
                        w_base_next  = r_base + 2'd1;
                        w_dwell_next = DWELL_RELOAD;
                    end else begin
                        w_dwell_next = r_dwell - DW'(1);
                    end
                    if (!autoEn) w_state_next = ST_MANUAL;
                end
            end
            ST_OVERRIDE: begin
                // Toggling autoEn while overridden redirects where the override returns to.
                if (autoEn != (r_ret == ST_AUTO)) w_ret_next = autoEn ? ST_AUTO : ST_MANUAL;
                if (w_chg_any) begin
                    w_ov_next   = w_chg_mode;
                    w_hold_next = HOLD_RELOAD;
                end else if (r_next_pulse || r_hold == '0) begin
                    if (r_next_pulse) w_base_next = r_base + 2'd1;
                    w_state_next = w_ret_next;
                    if (w_ret_next == ST_AUTO) w_dwell_next = DWELL_RELOAD;
                end else begin
                    w_hold_next = r_hold - HW'(1);
                end
            end
            default: begin
                w_state_next = ST_MANUAL;
                w_ret_next   = ST_MANUAL;
            end
        endcase
        w_sel_next = (w_state_next == ST_OVERRIDE) ? w_ov_next : w_base_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_MANUAL;
            r_ret          <= ST_MANUAL;
            r_base         <= '0;
            r_ov           <= '0;
            r_dwell        <= '0;
            r_hold         <= '0;
            r_sel          <= '0;
            r_ov_active    <= 1'b0;
            r_mode_changed <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_ret          <= w_ret_next;
            r_base         <= w_base_next;
            r_ov           <= w_ov_next;
            r_dwell        <= w_dwell_next;
            r_hold         <= w_hold_next;
            r_sel          <= w_sel_next;
            r_ov_active    <= (w_state_next == ST_OVERRIDE);
            r_mode_changed <= (w_sel_next != r_sel);
        end
    end

    assign selectInput    = r_sel;
    assign overrideActive = r_ov_active;
    assign modeChanged    = r_mode_changed;

endmodule

// File: tb/tb_display_mode_scheduler.sv
// Directed bench for display_mode_scheduler with DWELL=8, HOLD=5, DEBOUNCE=3:
// a cycle-by-cycle vector table plus hand-written auto-scroll and reset sequences.
module tb_display_mode_scheduler;

    logic       clk;
    logic       rst_n;
    logic       btnNext;
    logic       autoEn;
    logic [3:0] isoValue;
    logic [3:0] shutterSpeedValue;
    logic [3:0] focalLenghtValue;
    logic [2:0] brightnessIndicatorValue;
    logic [1:0] selectInput;
    logic       overrideActive;
    logic       modeChanged;

    int checks = 0;
    int errors = 0;

    display_mode_scheduler #(
        .DWELL_CYCLES   (8),
        .HOLD_CYCLES    (5),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .btnNext                 (btnNext),
        .autoEn                  (autoEn),
        .isoValue                (isoValue),
        .shutterSpeedValue       (shutterSpeedValue),
        .focalLenghtValue        (focalLenghtValue),
        .brightnessIndicatorValue(brightnessIndicatorValue),
        .selectInput             (selectInput),
        .overrideActive          (overrideActive),
        .modeChanged             (modeChanged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        btn;
        logic [3:0]  iso;
        logic [3:0]  sh;
        logic [3:0]  fo;
        logic [1:0]  sel;
        logic        ov;
        logic        mc;
        int unsigned n;
    } vec_t;

    vec_t vecs [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [1:0] exp_sel,
                             input logic exp_ov, input logic exp_mc);
        checks++;
        if (selectInput !== exp_sel || overrideActive !== exp_ov || modeChanged !== exp_mc) begin
            errors++;
            $display("FAIL %s: got sel=%b ov=%b mc=%b, want sel=%b ov=%b mc=%b at %0t",
                     name, selectInput, overrideActive, modeChanged,
                     exp_sel, exp_ov, exp_mc, $time);
        end
    endtask

    initial begin
        // Each row holds its inputs for n clock edges; outputs are expected after every edge.
        vecs[0]  = '{1'b0, 4'd2, 4'd3, 4'd1, 2'd0, 1'b0, 1'b0, 4};  // idle, nonzero values at reset
        vecs[1]  = '{1'b1, 4'd2, 4'd3, 4'd1, 2'd0, 1'b0, 1'b0, 5};  // press: sync + debounce
        vecs[2]  = '{1'b1, 4'd2, 4'd3, 4'd1, 2'd1, 1'b0, 1'b1, 1};  // step to shutter
        vecs[3]  = '{1'b0, 4'd2, 4'd3, 4'd1, 2'd1, 1'b0, 1'b0, 6};  // release does nothing
        vecs[4]  = '{1'b1, 4'd2, 4'd3, 4'd1, 2'd1, 1'b0, 1'b0, 2};  // 2-cycle glitch
        vecs[5]  = '{1'b0, 4'd2, 4'd3, 4'd1, 2'd1, 1'b0, 1'b0, 6};
        vecs[6]  = '{1'b0, 4'd5, 4'd3, 4'd7, 2'd0, 1'b1, 1'b1, 1};  // iso+focal: ISO wins
        vecs[7]  = '{1'b0, 4'd5, 4'd3, 4'd7, 2'd0, 1'b1, 1'b0, 1};
        vecs[8]  = '{1'b0, 4'd5, 4'd3, 4'd4, 2'd2, 1'b1, 1'b1, 1};  // focal retargets, hold reload
        vecs[9]  = '{1'b0, 4'd5, 4'd3, 4'd4, 2'd2, 1'b1, 1'b0, 3};
        vecs[10] = '{1'b1, 4'd5, 4'd3, 4'd4, 2'd2, 1'b1, 1'b0, 1};  // press begins, hold hits 0
        vecs[11] = '{1'b1, 4'd5, 4'd3, 4'd4, 2'd1, 1'b0, 1'b1, 1};  // back to base
        vecs[12] = '{1'b1, 4'd5, 4'd9, 4'd4, 2'd1, 1'b1, 1'b0, 3};  // override to shown mode: no pulse
        vecs[13] = '{1'b1, 4'd5, 4'd9, 4'd4, 2'd2, 1'b0, 1'b1, 1};  // press cancels override
        vecs[14] = '{1'b0, 4'd5, 4'd9, 4'd4, 2'd2, 1'b0, 1'b0, 8};

        rst_n                    = 1'b0;
        btnNext                  = 1'b0;
        autoEn                   = 1'b0;
        isoValue                 = 4'd2;
        shutterSpeedValue        = 4'd3;
        focalLenghtValue         = 4'd1;
        brightnessIndicatorValue = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            for (int unsigned k = 0; k < vecs[i].n; k++) begin
                btnNext           = vecs[i].btn;
                isoValue          = vecs[i].iso;
                shutterSpeedValue = vecs[i].sh;
                focalLenghtValue  = vecs[i].fo;
                brightnessIndicatorValue = 3'(i);
                step();
                check_out($sformatf("vec%0d_%0d", i, k), vecs[i].sel, vecs[i].ov, vecs[i].mc);
            end
        end

        // Auto-scroll from base 2: a new mode every 8 edges, first change 8 edges after entry.
        autoEn = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            logic [1:0] es;
            es = 2'((2 + (k - 1) / 8) % 4);
            step();
            check_out($sformatf("auto_%0d", k), es, 1'b0, (k > 1) && ((k - 1) % 8 == 0));
        end

        // Shutter change while showing shutter in AUTO: override without a pulse.
        shutterSpeedValue = 4'd4;
        step();
        check_out("auto_ov_enter", 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_out($sformatf("auto_ov_hold_%0d", k), 2'd1, 1'b1, 1'b0);
        end
        step();
        check_out("auto_ov_exit", 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            check_out($sformatf("auto_dwell_%0d", k), 2'd1, 1'b0, 1'b0);
        end
        step();
        check_out("auto_dwell_full", 2'd2, 1'b0, 1'b1);

        // Reset asserted in the middle of an override.
        shutterSpeedValue = 4'd6;
        step();
        check_out("mid_ov_enter", 2'd1, 1'b1, 1'b1);
        step();
        check_out("mid_ov_hold", 2'd1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 2'd0, 1'b0, 1'b0);
        step();
        step();
        check_out("reset_held", 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check_out("post_reset_prime", 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            check_out($sformatf("post_reset_auto_%0d", k), 2'd0, 1'b0, 1'b0);
        end
        step();
        check_out("post_reset_step", 2'd1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
